regfile: RTL and testbench

- Integer register file (x0–x31) for the single-cycle RV32I datapath.
- Feeds the ALU operand path: rd1 drives SrcA; rd2 is the register input of the SrcB 2:1 select and the store-data path.
- Written at the end of every instruction by the 4:1 result select (ALU result / memory read data / PC+4 / immediate).
- Two combinational read ports and one synchronous write port. x0 is hardwired to zero.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/regfile.sv | 66 ++++++
 tb/tb_regfile.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I datapath types and constants for the register file
package riscv_pkg;

  // Architectural data width and register count of the integer file
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   regaddr_t;

  // x0 address: reads as zero, writes are discarded
  localparam regaddr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - RV32I integer register file, two async read ports, one sync write port (option: REGFILE_BYPASS_EN)
import riscv_pkg::*;

module regfile #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic [AW-1:0]   a3,
  input  logic            we3,
  input  logic [XLEN-1:0] wd3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  // x0 address resized to this instance's address width
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  // A write only lands for a non-x0 target; x0 storage is never updated
  assign wr_en = we3 && (a3 != ZERO_ADDR);

  // Register array: async clear on reset, otherwise a single write per rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[a3] <= wd3;
    end
  end

  // Read port 1: zero for x0 or during reset, else stored value (optionally write-first)
  always_comb begin
    rd1 = '0;
    if (!reset && (a1 != ZERO_ADDR)) begin
      rd1 = regs[a1];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (a3 == a1)) begin
        rd1 = wd3;
      end
`endif
    end
  end

  // Read port 2: same selection as port 1, addressed by a2
  always_comb begin
    rd2 = '0;
    if (!reset && (a2 != ZERO_ADDR)) begin
      rd2 = regs[a2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (a3 == a2)) begin
        rd2 = wd3;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed self-checking bench for regfile
module tb_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  a1, a2, a3;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2;

  int checks;
  int fails;

  regfile dut (
    .clk   (clk),
    .reset (reset),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .we3   (we3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance past the next rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; we3 = 1'b0; a1 = 5'd5; a2 = 5'd31; a3 = 5'd0; wd3 = '0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin fails++; $display("FAIL reset_rd1_pre_edge: got %h want %h", rd1, 32'h0); end
    checks++;
    if (rd2 !== 32'h0) begin fails++; $display("FAIL reset_rd2_pre_edge: got %h want %h", rd2, 32'h0); end
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (rd1 !== 32'h0) begin fails++; $display("FAIL reset_write_ignored: got %h want %h", rd1, 32'h0); end
    @(negedge clk);
    we3 = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin fails++; $display("FAIL reset_release_x5: got %h want %h", rd1, 32'h0); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'h1234_5678;
    tick();
    we3 = 1'b0;
    a1 = 5'd5; a2 = 5'd6;
    #1;
    checks++;
    if (rd1 !== 32'h1234_5678) begin fails++; $display("FAIL write_read_x5: got %h want %h", rd1, 32'h1234_5678); end
    checks++;
    if (rd2 !== 32'h0) begin fails++; $display("FAIL write_read_x6: got %h want %h", rd2, 32'h0); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFF_FFFF; a1 = 5'd0; a2 = 5'd0;
    tick();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin fails++; $display("FAIL x0_rd1: got %h want %h", rd1, 32'h0); end
    checks++;
    if (rd2 !== 32'h0) begin fails++; $display("FAIL x0_rd2: got %h want %h", rd2, 32'h0); end
  endtask

  task automatic test_we_gating();
    @(negedge clk);
    we3 = 1'b0; a3 = 5'd7; wd3 = 32'hA5A5_A5A5; a1 = 5'd7; a2 = 5'd5;
    tick();
    checks++;
    if (rd1 !== 32'h0) begin fails++; $display("FAIL we_gating_x7: got %h want %h", rd1, 32'h0); end
    checks++;
    if (rd2 !== 32'h1234_5678) begin fails++; $display("FAIL we_gating_x5_hold: got %h want %h", rd2, 32'h1234_5678); end
  endtask

  task automatic test_raw();
    logic [31:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h22;
`else
    exp_pre = 32'h11;
`endif
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h11;
    tick();
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h22; a1 = 5'd9; a2 = 5'd5;
    #1;
    checks++;
    if (rd1 !== exp_pre) begin fails++; $display("FAIL raw_pre_edge: got %h want %h", rd1, exp_pre); end
    checks++;
    if (rd2 !== 32'h1234_5678) begin fails++; $display("FAIL raw_other_port: got %h want %h", rd2, 32'h1234_5678); end
    tick();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h22) begin fails++; $display("FAIL raw_post_edge: got %h want %h", rd1, 32'h22); end
  endtask

  task automatic test_same_addr();
    a1 = 5'd9; a2 = 5'd9;
    #1;
    checks++;
    if (rd1 !== 32'h22) begin fails++; $display("FAIL same_addr_rd1: got %h want %h", rd1, 32'h22); end
    checks++;
    if (rd2 !== 32'h22) begin fails++; $display("FAIL same_addr_rd2: got %h want %h", rd2, 32'h22); end
  endtask

  task automatic test_midop_reset();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we3 = 1'b1; a3 = 5'(i); wd3 = 32'(i);
      tick();
    end
    @(negedge clk);
    we3 = 1'b0;
    for (int i = 1; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(32 - i);
      #1;
      checks++;
      if (rd1 !== 32'(i)) begin fails++; $display("FAIL fill_rd1_x%0d: got %h want %h", i, rd1, 32'(i)); end
      checks++;
      if (rd2 !== 32'(32 - i)) begin fails++; $display("FAIL fill_rd2_x%0d: got %h want %h", 32 - i, rd2, 32'(32 - i)); end
    end
    // reset between edges, with a write pending on the next edge
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'hFFFF_0000;
    reset = 1'b1;
    for (int i = 1; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(i);
      #1;
      checks++;
      if (rd1 !== 32'h0) begin fails++; $display("FAIL midop_reset_rd1_x%0d: got %h want %h", i, rd1, 32'h0); end
      checks++;
      if (rd2 !== 32'h0) begin fails++; $display("FAIL midop_reset_rd2_x%0d: got %h want %h", i, rd2, 32'h0); end
    end
    tick();
    @(negedge clk);
    we3 = 1'b0;
    reset = 1'b0;
    a1 = 5'd3; a2 = 5'd31;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin fails++; $display("FAIL midop_write_blocked_x3: got %h want %h", rd1, 32'h0); end
    checks++;
    if (rd2 !== 32'h0) begin fails++; $display("FAIL midop_cleared_x31: got %h want %h", rd2, 32'h0); end
    // first write after release takes effect on the first edge
    we3 = 1'b1; a3 = 5'd4; wd3 = 32'h77; a1 = 5'd4;
    tick();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h77) begin fails++; $display("FAIL post_reset_first_write: got %h want %h", rd1, 32'h77); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_write_read();
    test_x0();
    test_we_gating();
    test_raw();
    test_same_addr();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
